pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline sequencing controller for the bittyCore five-stage pipeline: PC, IF, ID, EX, MEM, WB.
- Merges stall requests from ID, EX (multi-cycle ops) and MEM (bus wait) into a per-stage freeze vector.
- Turns taken-branch decisions from EX into a registered flush plus redirect PC.
- Masks wrong-path requests during the flush window.
- Keeps saturating stall/flush performance counters and a stall watchdog.
- Sits beside the datapath; drives the stall and flush inputs of pc_reg and the inter-stage registers.

## Interface
- FLUSH_CYCLES, 2: cycles after a redirect during which EX branch and ID/EX stall requests are ignored; legal range 1..15.
- CNT_W, 32: width of the performance counters.
- STALL_TIMEOUT, 1024: consecutive stall cycles that raise timeout_o; 0 disables the watchdog.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset (`RstEnable` = 0).
- stallreq_id_i  in  1  ID requests a stall (load-use hazard).
- stallreq_ex_i  in  1  EX requests a stall (multi-cycle op not done).
- stallreq_mem_i  in  1  MEM requests a stall (bus not ready).
- branch_flag_i  in  1  EX resolved a taken branch or jump this cycle.
- branch_addr_i  in  32  target of that branch.
- stall_o  out  6  freeze vector; bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
- flush_o  out  1  one-cycle pulse that squashes IF/ID and ID/EX.
- new_pc_o  out  32  redirect address; valid while flush_o = 1.
- stall_cnt_o  out  CNT_W  cycles with stall_o != 0, saturating.
- flush_cnt_o  out  CNT_W  accepted redirects, saturating.
- timeout_o  out  1  sticky; stall persisted STALL_TIMEOUT consecutive cycles.

## Operation
- States: RUN, FLUSH. A down-counter fcnt (4 bits) is active in FLUSH.
- Effective requests: id_eff = stallreq_id_i & (state==RUN), ex_eff = stallreq_ex_i & (state==RUN), mem_eff = stallreq_mem_i.
- stall_o is combinational, with priority MEM > EX > ID:
  - mem_eff: 6'b011111
  - ex_eff: 6'b001111
  - id_eff: 6'b000111
  - otherwise: 6'b000000
- Branch accept: state==RUN & branch_flag_i & !stallreq_ex_i & !stallreq_mem_i.
- On accept:
  - Next edge registers flush_o=1 and new_pc_o=branch_addr_i.
  - State goes to FLUSH with fcnt=FLUSH_CYCLES-1.
  - flush_cnt_o increments.
- FLUSH:
  - flush_o=1 only in its first cycle, then 0.
  - Each non-mem-stalled cycle, fcnt decrements if nonzero.
  - Return to RUN on the edge where fcnt==0 and !stallreq_mem_i.
  - A MEM stall freezes fcnt.
- A branch held in EX by a stall is not accepted until the stall clears. No pending register exists; EX holds the branch.
- new_pc_o holds its last value when flush_o=0.
- Counters saturate at all-ones and never wrap.
- Watchdog: scnt counts consecutive cycles with stall_o!=0 and clears on any stall-free cycle. When scnt reaches STALL_TIMEOUT, timeout_o sets and stays set until reset.

## Timing
- Reset (rst=0 at an edge):
  - state=RUN, fcnt=0.
  - flush_o=0, new_pc_o=32'h0.
  - stall_cnt_o=0, flush_cnt_o=0, scnt=0, timeout_o=0.
  - stall_o=0 while rst=0.
- Reset mid-FLUSH aborts the flush; no flush_o after reset.
- stall_o has zero latency from its requests.
- Redirect has 1-cycle latency: branch accepted in cycle N gives flush_o and new_pc_o in cycle N+1.
- Simultaneous branch_flag_i and stallreq_mem_i: stall wins, no accept, stall_o=6'b011111.
- Simultaneous branch_flag_i and stallreq_id_i in RUN: accept, and stall_o=6'b000111 in that cycle.
- stall_cnt_o increments on the edge following each cycle with stall_o!=0; the value is visible the next cycle.

## Structure
- Add to bitty_defs.v:
  - `StallBus` (5:0), `Stop`/`NoStop`.
  - STALL_MEM/EX/ID/NONE vector constants.
  - `FlushEnable`/`FlushDisable`.
- Sub-module `sat_counter` (parameter W; inc, clear, q), used three times: stall, flush and watchdog counters.
- FSM, fcnt and redirect registers live in pipe_ctrl itself.

## Test plan
- Reset: drive random inputs with rst=0 for 3 cycles, then release → all outputs 0, state RUN, stall_o=0 with no requests.
- Priority: id=1, ex=1, mem=1 → 6'b011111; drop mem → 6'b001111; drop ex → 6'b000111; stall_cnt_o=3 after three cycles.
- Redirect: branch_flag_i=1, addr 32'h0000_0100 in cycle N → flush_o=1 and new_pc_o=32'h100 in N+1 only; branch_flag_i=1 in N+1 and N+2 ignored; flush_cnt_o=1.
- Branch under MEM stall: branch_flag_i=1 with stallreq_mem_i=1 for 4 cycles, then mem=0 → single flush_o exactly one cycle after the stall clears; stallreq_id_i inside FLUSH gives stall_o=0.
- Watchdog: STALL_TIMEOUT=8, hold stallreq_ex_i for 7 cycles, release one cycle, hold for 8 → timeout_o=0 after the first burst, 1 after the 8th cycle of the second, stays 1 after release.
- Saturation and reset mid-FLUSH: CNT_W=4, 20 stall cycles → stall_cnt_o=4'hF; assert rst during FLUSH → no flush_o, RUN after release.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared encodings for the pipeline sequencing controller.
package pipe_ctrl_pkg;
   typedef enum logic {RUN, FLUSH} state_t;
   typedef logic [5:0] stall_bus_t;
   localparam logic RST_ENABLE = 1'b0;
   localparam logic STOP = 1'b1;
   localparam logic NO_STOP = 1'b0;
   localparam logic FLUSH_ENABLE = 1'b1;
   localparam logic FLUSH_DISABLE = 1'b0;
   localparam stall_bus_t STALL_MEM = 6'b011111;
   localparam stall_bus_t STALL_EX = 6'b001111;
   localparam stall_bus_t STALL_ID = 6'b000111;
   localparam stall_bus_t STALL_NONE = 6'b000000;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, with synchronous clear.
module sat_counter
   import pipe_ctrl_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clear,
   output logic [W-1:0] q
);
   always_ff @(posedge clk)
      if (rst == RST_ENABLE || clear) q <= '0;
      else if (inc && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges stage stall requests into a freeze vector and turns
// taken branches from EX into a registered flush plus redirect PC.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W = 32,
   parameter int STALL_TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stallreq_id_i,
   input  logic             stallreq_ex_i,
   input  logic             stallreq_mem_i,
   input  logic             branch_flag_i,
   input  logic [31:0]      branch_addr_i,
   output logic [5:0]       stall_o,
   output logic             flush_o,
   output logic [31:0]      new_pc_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output logic             timeout_o
);
   localparam int WD_W = $clog2(STALL_TIMEOUT + 2);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(STALL_TIMEOUT == 0 ? 0 : STALL_TIMEOUT - 1);
   localparam logic [3:0] FC_INIT = 4'(FLUSH_CYCLES - 1);
   state_t state;
   logic [3:0] fcnt;
   logic run, accept, stalled;
   logic [WD_W-1:0] scnt;
   assign run = state == RUN;
   assign accept = run & branch_flag_i & ~stallreq_ex_i & ~stallreq_mem_i;
   // Wrong-path ID/EX requests are masked while the flush window is open.
   assign stall_o = rst == RST_ENABLE ? STALL_NONE :
                    stallreq_mem_i ? STALL_MEM :
                    stallreq_ex_i & run ? STALL_EX :
                    stallreq_id_i & run ? STALL_ID : STALL_NONE;
   assign stalled = |stall_o;
   always_ff @(posedge clk)
      if (rst == RST_ENABLE) begin
         state <= RUN;
         fcnt <= '0;
         flush_o <= FLUSH_DISABLE;
         new_pc_o <= '0;
      end else begin
         flush_o <= accept;
         if (accept) begin
            state <= FLUSH;
            fcnt <= FC_INIT;
            new_pc_o <= branch_addr_i;
         end else if (state == FLUSH && !stallreq_mem_i) begin
            if (fcnt == 4'd0) state <= RUN;
            else fcnt <= fcnt - 4'd1;
         end
      end
   always_ff @(posedge clk)
      if (rst == RST_ENABLE) timeout_o <= 1'b0;
      else if (STALL_TIMEOUT != 0 && stalled && scnt == WD_LAST) timeout_o <= 1'b1;
   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk(clk), .rst(rst), .inc(stalled), .clear(1'b0), .q(stall_cnt_o)
   );
   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk(clk), .rst(rst), .inc(accept), .clear(1'b0), .q(flush_cnt_o)
   );
   sat_counter #(.W(WD_W)) u_watchdog (
      .clk(clk), .rst(rst), .inc(stalled), .clear(~stalled), .q(scnt)
   );
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios plus randomized traffic checked against a
// cycle-level behavioural model of the controller.
module tb_pipe_ctrl;
   logic clk = 1'b0, rst = 1'b0;
   logic id = 1'b0, ex = 1'b0, mem = 1'b0, br = 1'b0;
   logic [31:0] addr = '0;
   logic [5:0] stall_o;
   logic flush_o, timeout_o;
   logic [31:0] new_pc_o;
   logic [3:0] stall_cnt_o, flush_cnt_o;
   int checks = 0, failures = 0;
   int m_win = 0, m_stalls = 0, m_flushes = 0, m_run = 0;
   logic m_flush = 1'b0, m_to = 1'b0;
   logic [31:0] m_pc = '0;

   always #5 clk = ~clk;

   pipe_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4), .STALL_TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .stallreq_id_i(id), .stallreq_ex_i(ex),
      .stallreq_mem_i(mem), .branch_flag_i(br), .branch_addr_i(addr),
      .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
      .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o), .timeout_o(timeout_o)
   );

   function automatic logic [5:0] m_stall_vec();
      if (!rst) return 6'b000000;
      if (mem) return 6'b011111;
      if (m_win == 0 && ex) return 6'b001111;
      if (m_win == 0 && id) return 6'b000111;
      return 6'b000000;
   endfunction

   // Advance the model with the current inputs, then cross one rising edge.
   task automatic tick();
      logic acc;
      logic [5:0] sv;
      sv = m_stall_vec();
      acc = rst && m_win == 0 && br && !ex && !mem;
      if (!rst) begin
         m_win = 0; m_stalls = 0; m_flushes = 0; m_run = 0;
         m_flush = 1'b0; m_to = 1'b0; m_pc = '0;
      end else begin
         m_flush = acc;
         if (acc) begin
            m_pc = addr;
            m_win = 2;
            m_flushes = m_flushes < 15 ? m_flushes + 1 : 15;
         end else if (m_win > 0 && !mem) m_win--;
         if (sv != 0) begin
            m_stalls = m_stalls < 15 ? m_stalls + 1 : 15;
            m_run++;
         end else m_run = 0;
         if (m_run >= 8) m_to = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic i, input logic e, input logic m, input logic b, input logic [31:0] a);
      id = i; ex = e; mem = m; br = b; addr = a;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      drive(0, 0, 0, 0, 0);
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
         #2;
         checks++;
         if (stall_o !== 6'b0) begin failures++; $display("FAIL reset_stall got=%b exp=000000", stall_o); end
         tick();
      end
      rst = 1'b1;
      drive(0, 0, 0, 0, 0);
      #2;
      checks++;
      if ({stall_o, flush_o, new_pc_o, stall_cnt_o, flush_cnt_o, timeout_o} !== '0) begin
         failures++;
         $display("FAIL reset_outs stall=%b flush=%b pc=%h sc=%0d fc=%0d to=%b exp=all zero",
                  stall_o, flush_o, new_pc_o, stall_cnt_o, flush_cnt_o, timeout_o);
      end
      id = 1'b1;
      #1;
      checks++;
      if (stall_o !== 6'b000111) begin failures++; $display("FAIL reset_run got=%b exp=000111", stall_o); end
      tick();
      id = 1'b0;
   endtask

   task automatic test_priority();
      do_reset();
      drive(1, 1, 1, 0, 0);
      #2;
      checks++;
      if (stall_o !== 6'b011111) begin failures++; $display("FAIL prio_mem got=%b exp=011111", stall_o); end
      tick();
      mem = 1'b0;
      #2;
      checks++;
      if (stall_o !== 6'b001111) begin failures++; $display("FAIL prio_ex got=%b exp=001111", stall_o); end
      tick();
      ex = 1'b0;
      #2;
      checks++;
      if (stall_o !== 6'b000111) begin failures++; $display("FAIL prio_id got=%b exp=000111", stall_o); end
      tick();
      id = 1'b0;
      #2;
      checks++;
      if (stall_cnt_o !== 4'd3 || stall_o !== 6'b0) begin
         failures++; $display("FAIL prio_cnt cnt=%0d stall=%b exp=3 000000", stall_cnt_o, stall_o);
      end
   endtask

   task automatic test_redirect();
      do_reset();
      drive(0, 0, 0, 1, 32'h100);
      #2;
      checks++;
      if (flush_o !== 1'b0) begin failures++; $display("FAIL redir_pre flush=%b exp=0", flush_o); end
      tick();
      addr = 32'h200;
      #2;
      checks++;
      if (flush_o !== 1'b1 || new_pc_o !== 32'h100) begin
         failures++; $display("FAIL redir_pulse flush=%b pc=%h exp=1 00000100", flush_o, new_pc_o);
      end
      tick();
      addr = 32'h300;
      #2;
      checks++;
      if (flush_o !== 1'b0 || new_pc_o !== 32'h100) begin
         failures++; $display("FAIL redir_ign1 flush=%b pc=%h exp=0 00000100", flush_o, new_pc_o);
      end
      tick();
      br = 1'b0;
      #2;
      checks++;
      if (flush_o !== 1'b0 || new_pc_o !== 32'h100 || flush_cnt_o !== 4'd1) begin
         failures++; $display("FAIL redir_ign2 flush=%b pc=%h fc=%0d exp=0 00000100 1", flush_o, new_pc_o, flush_cnt_o);
      end
      tick();
   endtask

   task automatic test_mem_branch();
      do_reset();
      drive(0, 0, 1, 1, 32'h2000);
      for (int i = 0; i < 4; i++) begin
         #2;
         checks++;
         if (stall_o !== 6'b011111 || flush_o !== 1'b0) begin
            failures++; $display("FAIL membr_hold%0d stall=%b flush=%b exp=011111 0", i, stall_o, flush_o);
         end
         tick();
      end
      mem = 1'b0;
      #2;
      checks++;
      if (stall_o !== 6'b0 || flush_o !== 1'b0) begin
         failures++; $display("FAIL membr_clear stall=%b flush=%b exp=000000 0", stall_o, flush_o);
      end
      tick();
      drive(1, 0, 0, 0, 0);
      #2;
      checks++;
      if (flush_o !== 1'b1 || new_pc_o !== 32'h2000 || stall_o !== 6'b0) begin
         failures++; $display("FAIL membr_flush flush=%b pc=%h stall=%b exp=1 00002000 000000", flush_o, new_pc_o, stall_o);
      end
      tick();
      #2;
      checks++;
      if (flush_o !== 1'b0 || stall_o !== 6'b0 || flush_cnt_o !== 4'd1) begin
         failures++; $display("FAIL membr_win flush=%b stall=%b fc=%0d exp=0 000000 1", flush_o, stall_o, flush_cnt_o);
      end
      tick();
      #2;
      checks++;
      if (stall_o !== 6'b000111) begin failures++; $display("FAIL membr_run stall=%b exp=000111", stall_o); end
      tick();
      id = 1'b0;
   endtask

   task automatic test_watchdog();
      do_reset();
      ex = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      ex = 1'b0;
      #2;
      checks++;
      if (timeout_o !== 1'b0) begin failures++; $display("FAIL wd_burst1 to=%b exp=0", timeout_o); end
      tick();
      ex = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      checks++;
      if (timeout_o !== 1'b0) begin failures++; $display("FAIL wd_seven to=%b exp=0", timeout_o); end
      tick();
      checks++;
      if (timeout_o !== 1'b1) begin failures++; $display("FAIL wd_eight to=%b exp=1", timeout_o); end
      ex = 1'b0;
      tick();
      tick();
      checks++;
      if (timeout_o !== 1'b1) begin failures++; $display("FAIL wd_sticky to=%b exp=1", timeout_o); end
   endtask

   task automatic test_random();
      int bad = 0;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 49) != 0);
         drive($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
               $urandom_range(0, 2) == 0, $urandom);
         #2;
         if (stall_o !== m_stall_vec() || flush_o !== m_flush || new_pc_o !== m_pc ||
             stall_cnt_o !== 4'(m_stalls) || flush_cnt_o !== 4'(m_flushes) || timeout_o !== m_to) begin
            if (bad < 5)
               $display("FAIL random cyc=%0d got stall=%b fl=%b pc=%h sc=%0d fc=%0d to=%b exp stall=%b fl=%b pc=%h sc=%0d fc=%0d to=%b",
                        i, stall_o, flush_o, new_pc_o, stall_cnt_o, flush_cnt_o, timeout_o,
                        m_stall_vec(), m_flush, m_pc, m_stalls, m_flushes, m_to);
            bad++;
         end
         tick();
      end
      rst = 1'b1;
      checks++;
      if (bad != 0) failures++;
   endtask

   task automatic test_saturation_reset();
      do_reset();
      ex = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      ex = 1'b0;
      #2;
      checks++;
      if (stall_cnt_o !== 4'hF) begin failures++; $display("FAIL sat_cnt got=%h exp=f", stall_cnt_o); end
      br = 1'b1; addr = 32'h44;
      tick();
      br = 1'b0;
      #2;
      checks++;
      if (flush_o !== 1'b1) begin failures++; $display("FAIL midfl_enter flush=%b exp=1", flush_o); end
      rst = 1'b0;
      tick();
      rst = 1'b1;
      id = 1'b1;
      #2;
      checks++;
      if (flush_o !== 1'b0 || stall_o !== 6'b000111 || flush_cnt_o !== 4'd0 || new_pc_o !== 32'h0) begin
         failures++; $display("FAIL midfl_reset flush=%b stall=%b fc=%0d pc=%h exp=0 000111 0 0", flush_o, stall_o, flush_cnt_o, new_pc_o);
      end
      tick();
      id = 1'b0;
      #2;
      checks++;
      if (flush_o !== 1'b0) begin failures++; $display("FAIL midfl_after flush=%b exp=0", flush_o); end
   endtask

   initial begin
      test_reset();
      test_priority();
      test_redirect();
      test_mem_branch();
      test_watchdog();
      test_random();
      test_saturation_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
